// File: rtl/alu_control_seq_if.sv
// rtl/alu_control_seq_if.sv - decode request and ALU/MDU control bundle for alu_control_seq
interface alu_control_seq_if #(
  parameter int CTRL_W = 4
);
  logic              in_valid;
  logic              flush;
  logic [1:0]        alu_op;
  logic [5:0]        funct;
  logic [5:0]        opcode;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              jr;
  logic              illegal;
  logic [1:0]        mf_sel;
  logic              mdu_start;
  logic [1:0]        mdu_op;
  logic              busy;
  logic              hilo_we;
  logic              stall;

  modport master (
    output in_valid, flush, alu_op, funct, opcode,
    input  alu_ctrl, jr, illegal, mf_sel, mdu_start, mdu_op, busy, hilo_we, stall
  );

  modport slave (
    input  in_valid, flush, alu_op, funct, opcode,
    output alu_ctrl, jr, illegal, mf_sel, mdu_start, mdu_op, busy, hilo_we, stall
  );
endinterface

// File: rtl/alu_control_seq.sv
// rtl/alu_control_seq.sv - MIPS32 ALU control decode plus multi-cycle MDU sequencer
module alu_control_seq #(
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 32,
  parameter int DIV_CYCLES = 33,
  parameter int REG_OUT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  alu_control_seq_if.slave  bus
);
  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_XOR  = 4'b0011;
  localparam logic [3:0] C_NOR  = 4'b0100;
  localparam logic [3:0] C_SLL  = 4'b0101;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_SRL  = 4'b1000;
  localparam logic [3:0] C_SLTU = 4'b1001;
  localparam logic [3:0] C_NOP  = 4'b1111;
  localparam logic [5:0] MUL_N1 = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_N1 = 6'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic [1:0] op_q, op_nxt;
  logic       start_q, start_nxt;
  logic       hilo_we_c;

  logic [3:0] dec_ctrl;
  logic       dec_jr, dec_ill, is_mdu, is_mf;
  logic [1:0] dec_mf;
  logic       busy_c, stall_c;

  always_comb begin
    dec_ctrl = C_NOP;
    dec_jr   = 1'b0;
    dec_ill  = 1'b0;
    dec_mf   = 2'b00;
    is_mdu   = 1'b0;
    is_mf    = 1'b0;
    if (bus.in_valid) begin
      case (bus.alu_op)
        2'b00: dec_ctrl = C_ADD;
        2'b01: dec_ctrl = C_SUB;
        2'b10: begin
          case (bus.funct)
            6'b100000, 6'b100001: dec_ctrl = C_ADD;
            6'b100010, 6'b100011: dec_ctrl = C_SUB;
            6'b100100: dec_ctrl = C_AND;
            6'b100101: dec_ctrl = C_OR;
            6'b100110: dec_ctrl = C_XOR;
            6'b100111: dec_ctrl = C_NOR;
            6'b101010: dec_ctrl = C_SLT;
            6'b101011: dec_ctrl = C_SLTU;
            6'b000000: dec_ctrl = C_SLL;
            6'b000010: dec_ctrl = C_SRL;
            6'b001000: dec_jr = 1'b1;
            6'b011000, 6'b011001, 6'b011010, 6'b011011: is_mdu = 1'b1;
            6'b010000: begin dec_mf = 2'b01; is_mf = 1'b1; end
            6'b010010: begin dec_mf = 2'b10; is_mf = 1'b1; end
            default: dec_ill = 1'b1;
          endcase
        end
        default: begin
          case (bus.opcode)
            6'b001000, 6'b001001: dec_ctrl = C_ADD;
            6'b001100: dec_ctrl = C_AND;
            6'b001101: dec_ctrl = C_OR;
            6'b001110: dec_ctrl = C_XOR;
            6'b001010: dec_ctrl = C_SLT;
            6'b001011: dec_ctrl = C_SLTU;
            default:   dec_ill  = 1'b1;
          endcase
        end
      endcase
    end
  end

  // MFHI/MFLO wait through DONE so they observe the freshly written HI/LO
  assign busy_c  = (state != IDLE);
  assign stall_c = busy_c & (is_mdu | is_mf);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 6'd0;
      op_q    <= 2'b00;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      op_q    <= op_nxt;
      start_q <= start_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op_q;
    start_nxt = 1'b0;
    hilo_we_c = 1'b0;
    case (state)
      IDLE: begin
        if (is_mdu && !bus.flush) begin
          state_nxt = BUSY;
          cnt_nxt   = bus.funct[1] ? DIV_N1 : MUL_N1;
          op_nxt    = bus.funct[1:0];
          start_nxt = 1'b1;
        end
      end
      BUSY: begin
        if (bus.flush)       state_nxt = IDLE;
        else if (cnt == 6'd0) state_nxt = DONE;
        else                 cnt_nxt = cnt - 6'd1;
      end
      DONE: begin
        hilo_we_c = !bus.flush;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic [3:0] ctrl_o;
  logic       jr_o, ill_o;
  logic [1:0] mf_o;

  generate
    if (REG_OUT != 0) begin : g_reg
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ctrl_o <= C_NOP;
          jr_o   <= 1'b0;
          ill_o  <= 1'b0;
          mf_o   <= 2'b00;
        end else if (!stall_c) begin
          ctrl_o <= dec_ctrl;
          jr_o   <= dec_jr;
          ill_o  <= dec_ill;
          mf_o   <= dec_mf;
        end
      end
    end else begin : g_comb
      always_comb begin
        ctrl_o = dec_ctrl;
        jr_o   = dec_jr;
        ill_o  = dec_ill;
        mf_o   = dec_mf;
      end
    end
  endgenerate

  assign bus.alu_ctrl  = CTRL_W'(ctrl_o);
  assign bus.jr        = jr_o;
  assign bus.illegal   = ill_o;
  assign bus.mf_sel    = mf_o;
  assign bus.mdu_start = start_q;
  assign bus.mdu_op    = op_q;
  assign bus.busy      = busy_c;
  assign bus.hilo_we   = hilo_we_c;
  assign bus.stall     = stall_c;
endmodule
